audio_burst_sequencer: RTL and testbench

Controller that drives the audio PWM datapath. It generates the 17-bit frame counter `contador` and the 5-bit PWM reference `pwm_ref` for each frame, and sequences a programmable number of tone frames separated by silent gaps. It also produces the final 1-bit PWM audio pin. Software/FSM above issues `start`/`stop`; the block reports `busy` and a one-cycle `done`.

---
 rtl/audio_pwm_pkg.sv | 20 ++
 rtl/pwm_modulator.sv | 26 ++
 rtl/audio_burst_sequencer.sv | 154 +++++++++++++++
 tb/tb_audio_burst_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/audio_pwm_pkg.sv
// Shared definitions for the audio PWM burst sequencer: state encoding,
// default frame timing and level constants, and the PWM resolution.
package audio_pwm_pkg;

  localparam int PWM_W = 5;

  localparam logic [16:0] FRAME_MAX_DEF = 17'd131071;
  localparam logic [16:0] SPLIT_DEF     = 17'd80000;

  localparam logic [PWM_W-1:0] LVL_HI_DEF = 5'b11111;
  localparam logic [PWM_W-1:0] LVL_LO_DEF = 5'b00110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_GAP,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/pwm_modulator.sv
// Free-running 5-bit PWM modulator: the output is high while the sub-counter
// is below the duty reference, so a reference of 0 is always low and 31 is
// high for 31 of every 32 cycles.
module pwm_modulator
  import audio_pwm_pkg::*;
(
  input  logic             clk,
  input  logic             reset_central,
  input  logic [PWM_W-1:0] pwm_ref,
  output logic             pwm_out
);

  logic [PWM_W-1:0] sub_cnt;

  // Sub-counter wraps naturally at 31; the compare result is registered.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      sub_cnt <= '0;
      pwm_out <= 1'b0;
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
      pwm_out <= (sub_cnt < pwm_ref);
    end
  end

endmodule

// File: rtl/audio_burst_sequencer.sv
// Burst sequencer for the audio PWM path. Plays a programmable number of
// tone frames separated by silent gaps, generating the frame counter and the
// per-frame PWM duty reference; all outputs are registered.
module audio_burst_sequencer
  import audio_pwm_pkg::*;
#(
  parameter logic [16:0] FRAME_MAX = FRAME_MAX_DEF,
  parameter logic [16:0] SPLIT     = SPLIT_DEF,
  parameter logic [15:0] GAP_LEN   = 16'd1000
) (
  input  logic             clk,
  input  logic             reset_central,
  input  logic             start,
  input  logic             stop,
  input  logic [3:0]       n_frames,
  input  logic [PWM_W-1:0] level_hi,
  input  logic [PWM_W-1:0] level_lo,
  output logic [16:0]      contador,
  output logic [PWM_W-1:0] pwm_ref,
  output logic             pwm_out,
  output logic             busy,
  output logic             done
);

  // Last gap cycle index; unused when GAP_LEN is zero because GAP is skipped.
  localparam logic [15:0] GAP_LAST = GAP_LEN - 16'd1;

  seq_state_t       state, state_nxt;
  logic [16:0]      contador_nxt;
  logic [PWM_W-1:0] pwm_ref_nxt;
  logic             busy_nxt, done_nxt;
  logic [3:0]       frame_cnt, frame_nxt;
  logic [15:0]      gap_cnt, gap_nxt;
  logic [3:0]       n_lat, n_lat_nxt;
  logic [PWM_W-1:0] hi_lat, hi_lat_nxt;
  logic [PWM_W-1:0] lo_lat, lo_lat_nxt;

  // State, counters, latched settings and registered outputs.
  always_ff @(posedge clk or posedge reset_central) begin
    if (reset_central) begin
      state     <= S_IDLE;
      contador  <= '0;
      pwm_ref   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      n_lat     <= '0;
      hi_lat    <= '0;
      lo_lat    <= '0;
    end else begin
      state     <= state_nxt;
      contador  <= contador_nxt;
      pwm_ref   <= pwm_ref_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      frame_cnt <= frame_nxt;
      gap_cnt   <= gap_nxt;
      n_lat     <= n_lat_nxt;
      hi_lat    <= hi_lat_nxt;
      lo_lat    <= lo_lat_nxt;
    end
  end

  // Next state and next output values; outputs follow the upcoming state so
  // they line up with the state register after the edge.
  always_comb begin
    state_nxt    = state;
    contador_nxt = '0;
    pwm_ref_nxt  = '0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    frame_nxt    = frame_cnt;
    gap_nxt      = gap_cnt;
    n_lat_nxt    = n_lat;
    hi_lat_nxt   = hi_lat;
    lo_lat_nxt   = lo_lat;

    case (state)
      S_IDLE: begin
        if (start && !stop) begin
          n_lat_nxt  = n_frames;
          hi_lat_nxt = level_hi;
          lo_lat_nxt = level_lo;
          if (n_frames == 4'd0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_RUN;
            frame_nxt = 4'd1;
          end
        end
      end
      S_RUN: begin
        if (contador == FRAME_MAX) begin
          if (frame_cnt == n_lat) begin
            state_nxt = S_DONE;
          end else if (GAP_LEN == 16'd0) begin
            frame_nxt = frame_cnt + 4'd1;
          end else begin
            state_nxt = S_GAP;
            gap_nxt   = '0;
          end
        end else begin
          contador_nxt = contador + 17'd1;
        end
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = S_RUN;
          frame_nxt = frame_cnt + 4'd1;
        end else begin
          gap_nxt = gap_cnt + 16'd1;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (stop) begin
      state_nxt    = S_IDLE;
      contador_nxt = '0;
    end

    case (state_nxt)
      S_RUN: begin
        busy_nxt    = 1'b1;
        pwm_ref_nxt = (contador_nxt < SPLIT) ? hi_lat_nxt : lo_lat_nxt;
      end
      S_GAP: begin
        busy_nxt     = 1'b1;
        contador_nxt = '0;
      end
      S_DONE: begin
        done_nxt     = 1'b1;
        contador_nxt = '0;
      end
      default: begin
        contador_nxt = '0;
      end
    endcase
  end

  pwm_modulator u_pwm_modulator (
    .clk          (clk),
    .reset_central(reset_central),
    .pwm_ref      (pwm_ref),
    .pwm_out      (pwm_out)
  );

endmodule

// File: tb/tb_audio_burst_sequencer.sv
// Self-checking bench for audio_burst_sequencer with a small frame size.
// The reference model tracks time since start and derives the expected
// outputs arithmetically from the frame/gap layout of a burst.
module tb_audio_burst_sequencer;

  localparam logic [16:0] FM = 17'd99;
  localparam logic [16:0] SP = 17'd60;
  localparam logic [15:0] GL = 16'd10;
  localparam int FLEN = 100;
  localparam int GLEN = 10;
  localparam int SPI  = 60;

  logic        clk = 1'b0;
  logic        reset_central;
  logic        start, stop;
  logic [3:0]  n_frames;
  logic [4:0]  level_hi, level_lo;
  logic [16:0] contador;
  logic [4:0]  pwm_ref;
  logic        pwm_out, busy, done;

  int checks = 0;
  int errors = 0;

  bit m_active;
  int m_t, m_total, m_hi, m_lo, m_sub;
  int e_cnt, e_ref, e_busy, e_done, e_pwm;

  audio_burst_sequencer #(.FRAME_MAX(FM), .SPLIT(SP), .GAP_LEN(GL)) dut (
    .clk          (clk),
    .reset_central(reset_central),
    .start        (start),
    .stop         (stop),
    .n_frames     (n_frames),
    .level_hi     (level_hi),
    .level_lo     (level_lo),
    .contador     (contador),
    .pwm_ref      (pwm_ref),
    .pwm_out      (pwm_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelReset();
    m_active = 1'b0;
    m_t = 0; m_total = 0; m_sub = 0;
    e_cnt = 0; e_ref = 0; e_busy = 0; e_done = 0; e_pwm = 0;
  endtask

  // A burst of n frames is busy for n*FLEN + (n-1)*GLEN cycles, then done.
  task automatic modelEdge();
    int prev_sub, prev_ref, off;
    if (reset_central) begin
      modelReset();
      return;
    end
    prev_sub = m_sub;
    prev_ref = e_ref;
    m_sub = (m_sub + 1) % 32;
    e_pwm = (prev_sub < prev_ref) ? 1 : 0;
    if (stop) m_active = 1'b0;
    else if (m_active) begin
      m_t++;
      if (m_t > m_total) m_active = 1'b0;
    end else if (start) begin
      m_active = 1'b1;
      m_t = 0;
      m_hi = int'(level_hi);
      m_lo = int'(level_lo);
      m_total = (n_frames == 0) ? 0 : int'(n_frames) * FLEN + (int'(n_frames) - 1) * GLEN;
    end
    e_cnt = 0; e_ref = 0; e_busy = 0; e_done = 0;
    if (m_active) begin
      if (m_t < m_total) begin
        e_busy = 1;
        off = m_t % (FLEN + GLEN);
        if (off < FLEN) begin
          e_cnt = off;
          e_ref = (off < SPI) ? m_hi : m_lo;
        end
      end else begin
        e_done = 1;
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("contador", 32'(contador), 32'(e_cnt));
    checkOutput("pwm_ref",  32'(pwm_ref),  32'(e_ref));
    checkOutput("busy",     32'(busy),     32'(e_busy));
    checkOutput("done",     32'(done),     32'(e_done));
    checkOutput("pwm_out",  32'(pwm_out),  32'(e_pwm));
  endtask

  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic [3:0] n,
                               input logic [4:0] hi, input logic [4:0] lo);
    start = s; stop = p; n_frames = n; level_hi = hi; level_lo = lo;
    tick();
    start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    int cnt_a, cnt_b, done_at;
    reset_central = 1'b1;
    start = 0; stop = 0; n_frames = 0; level_hi = 0; level_lo = 0;
    modelReset();
    #2;
    checkAll();
    tick();
    @(negedge clk) reset_central = 1'b0;

    // Single frame: busy span, duty windows in the high and low halves.
    applyStimulus(1, 0, 4'd1, 5'd31, 5'd6);
    cnt_a = 0; cnt_b = 0; done_at = -1;
    for (int i = 1; i <= 110; i++) begin
      tick();
      if (i >= 10 && i <= 41 && pwm_out) cnt_a++;
      if (i >= 62 && i <= 93 && pwm_out) cnt_b++;
      if (done && done_at < 0) done_at = i;
    end
    checkOutput("duty_31", 32'(cnt_a), 32'd31);
    checkOutput("duty_6", 32'(cnt_b), 32'd6);
    checkOutput("n1_done_at", 32'(done_at), 32'd100);

    // Three frames with two gaps: done exactly once, 320 edges after start.
    applyStimulus(1, 0, 4'd3, 5'd17, 5'd4);
    cnt_a = 0; done_at = -1;
    for (int i = 1; i <= 330; i++) begin
      tick();
      if (done) begin cnt_a++; done_at = i; end
    end
    checkOutput("n3_done_count", 32'(cnt_a), 32'd1);
    checkOutput("n3_done_at", 32'(done_at), 32'd320);

    // Zero frames: immediate done, never busy.
    applyStimulus(1, 0, 4'd0, 5'd9, 5'd9);
    checkOutput("n0_done", 32'(done), 32'd1);
    checkOutput("n0_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();

    // Stop at contador 45 in the second frame, then restart.
    applyStimulus(1, 0, 4'd3, 5'd12, 5'd2);
    for (int i = 0; i < 155; i++) tick();
    checkOutput("stop_pre_cnt", 32'(contador), 32'd45);
    applyStimulus(0, 1, 4'd0, 5'd0, 5'd0);
    checkOutput("stop_busy", 32'(busy), 32'd0);
    cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) cnt_a++;
    end
    checkOutput("stop_no_done", 32'(cnt_a), 32'd0);
    applyStimulus(1, 0, 4'd1, 5'd20, 5'd1);
    checkOutput("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 30; i++) tick();

    // Start while busy with different settings is ignored.
    applyStimulus(1, 0, 4'd0, 5'd3, 5'd3);
    for (int i = 0; i < 90; i++) tick();

    // Start and stop together in idle does not begin a burst.
    applyStimulus(1, 1, 4'd2, 5'd25, 5'd25);
    checkOutput("startstop_busy", 32'(busy), 32'd0);
    tick();

    // Asynchronous reset in the middle of a frame.
    applyStimulus(1, 0, 4'd2, 5'd31, 5'd31);
    for (int i = 0; i < 30; i++) tick();
    #2 reset_central = 1'b1;
    #1;
    modelReset();
    checkOutput("areset_cnt", 32'(contador), 32'd0);
    checkOutput("areset_ref", 32'(pwm_ref), 32'd0);
    checkOutput("areset_pwm", 32'(pwm_out), 32'd0);
    checkOutput("areset_busy", 32'(busy), 32'd0);
    tick();
    @(negedge clk) reset_central = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    // Randomized start/stop traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      start    = ($urandom % 40) == 0;
      stop     = ($urandom % 300) == 0;
      n_frames = 4'($urandom % 4);
      level_hi = 5'($urandom);
      level_lo = 5'($urandom);
      tick();
    end
    start = 0; stop = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
